store_write_buffer: RTL and testbench

- Posted-store FIFO between the single-cycle CPU data port and data_mem.
- Accepts each CPU store in zero extra cycles and retires buffered stores to data_mem, one per cycle, whenever the memory port is free.
- Loads check the buffer youngest-first for a matching entry so the CPU never reads stale data.
- Stalls the CPU only when the buffer is full, or on a load hazard when forwarding is compiled out.

---
 rtl/store_write_buffer.sv | 124 ++++++++++++
 tb/tb_store_write_buffer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/store_write_buffer.sv
// rtl/store_write_buffer.sv - posted-store FIFO between CPU data port and data_mem; load forwarding via STORE_WB_FORWARD_EN
module store_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [AW-1:0]            cpu_adr,
  input  logic [DW-1:0]            cpu_wdata,
  input  logic                     cpu_read,
  input  logic                     cpu_write,
  output logic [DW-1:0]            cpu_rdata,
  output logic                     cpu_stall,
  output logic [AW-1:0]            mem_adr,
  output logic [DW-1:0]            mem_wdata,
  output logic                     mem_read,
  output logic                     mem_write,
  input  logic [DW-1:0]            mem_rdata,
  output logic [$clog2(DEPTH):0]   buf_count,
  output logic                     buf_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] adr_q  [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic          full;
  logic          is_load;
  logic          hit;
  logic [DW-1:0] hit_data;
  logic [PW-1:0] idx;
  logic          fwd_hit;
  logic          hazard;
  logic          port_claimed;
  logic          drain;
  logic          accept;

  // Scan occupied entries oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if ((CW'(k) < count) && (adr_q[idx][AW-1:2] == cpu_adr[AW-1:2])) begin
        hit      = 1'b1;
        hit_data = data_q[idx];
      end
    end
  end

  // Request decode: a read request holds the memory port unless it is a pure load that hits the buffer.
  always_comb begin
    full    = (count == CW'(DEPTH));
    is_load = cpu_read & ~cpu_write;
`ifdef STORE_WB_FORWARD_EN
    fwd_hit = is_load & hit;
    hazard  = 1'b0;
`else
    fwd_hit = 1'b0;
    hazard  = is_load & hit;
`endif
    port_claimed = cpu_read & ~(is_load & hit);
    drain        = (count != '0) & ~port_claimed;
    accept       = cpu_write & ~full;
  end

  // Output drive; everything is forced low while reset is asserted so memory never sees a partial write.
  always_comb begin
    cpu_stall = rst & ((cpu_write & full) | hazard);
    mem_read  = rst & is_load & ~hit;
    mem_write = rst & drain;
    mem_adr   = '0;
    mem_wdata = '0;
    cpu_rdata = '0;
    if (mem_read) begin
      mem_adr = cpu_adr;
    end else if (mem_write) begin
      mem_adr   = adr_q[head];
      mem_wdata = data_q[head];
    end
    if (rst) begin
      if (mem_read) begin
        cpu_rdata = mem_rdata;
      end else if (fwd_hit) begin
        cpu_rdata = hit_data;
      end
    end
    buf_count = count;
    buf_empty = (count == '0);
  end

  // Entry storage is written only on an accepted store; contents need no reset since count gates validity.
  always_ff @(posedge clk) begin
    if (accept) begin
      adr_q[tail]  <= cpu_adr;
      data_q[tail] <= cpu_wdata;
    end
  end

  // Pointer and occupancy bookkeeping; a simultaneous store and drain leaves the count unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (accept) tail <= tail + 1'b1;
      if (drain)  head <= head + 1'b1;
      case ({accept, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// tb/tb_store_write_buffer.sv - scoreboard bench for store_write_buffer against an architectural memory model
module tb_store_write_buffer;

  localparam int DEPTH   = 4;
  localparam int K_IDLE  = 0;
  localparam int K_STORE = 1;
  localparam int K_LOAD  = 2;
  localparam int K_COMBO = 3;
`ifdef STORE_WB_FORWARD_EN
  localparam bit HAZ = 1'b0;
`else
  localparam bit HAZ = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_adr;
  logic [31:0] cpu_wdata;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic [31:0] mem_adr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;
  logic [2:0]  buf_count;
  logic        buf_empty;

  store_write_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .buf_count(buf_count), .buf_empty(buf_empty)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    return 32'h1000_0000 + i * 32'h0101;
  endfunction

  // data_mem model: combinational read, write on rising edge, reloaded while reset is held
  logic [31:0] phys [256];
  assign mem_rdata = phys[mem_adr[9:2]];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) phys[i] <= init_val(i);
    end else if (mem_write) begin
      phys[mem_adr[9:2]] <= mem_wdata;
    end
  end

  // architectural view of memory in program order, plus scoreboard queues
  logic [31:0] arch [256];
  logic [63:0] wq [$];
  logic [31:0] lq [$];
  int          checks = 0;
  int          failures = 0;
  int          cur_kind = K_IDLE;
  logic [31:0] cur_adr = '0;
  bit          mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // monitor: compare DUT behaviour against the pending-store list each cycle
  int          m_n;
  logic        m_st, m_ld, m_hit, e_stall, e_mr, e_mw;
  logic [63:0] m_w;
  always @(negedge clk) begin
    if (mon_en) begin
      m_st = (cur_kind == K_STORE) || (cur_kind == K_COMBO);
      m_ld = (cur_kind == K_LOAD);
      m_n  = wq.size() - (m_st ? 1 : 0);
      m_hit = 1'b0;
      for (int i = 0; i < m_n; i++)
        if (wq[i][63:34] == cur_adr[31:2]) m_hit = 1'b1;
      e_stall = m_st ? (m_n == DEPTH) : (m_ld && HAZ && m_hit);
      e_mr    = m_ld && !m_hit;
      e_mw    = (m_n != 0) && (cur_kind != K_COMBO) && !(m_ld && !m_hit);
      chk("buf_count", 32'(buf_count), 32'(m_n));
      chk("buf_empty", 32'(buf_empty), 32'(m_n == 0));
      chk("cpu_stall", 32'(cpu_stall), 32'(e_stall));
      chk("mem_read", 32'(mem_read), 32'(e_mr));
      chk("mem_write", 32'(mem_write), 32'(e_mw));
      if (mem_read) chk("mem_adr_load", mem_adr, cur_adr);
      if (mem_write) begin
        if (wq.size() == 0) begin
          chk("drain_without_store", 32'd1, 32'd0);
        end else begin
          m_w = wq.pop_front();
          chk("drain_adr", mem_adr, m_w[63:32]);
          chk("drain_data", mem_wdata, m_w[31:0]);
        end
      end
      if (m_ld && !cpu_stall) begin
        if (lq.size() == 0) chk("load_without_expect", 32'd1, 32'd0);
        else chk("load_rdata", cpu_rdata, lq.pop_front());
      end
      if (cur_kind == K_COMBO) chk("combo_rdata", cpu_rdata, 32'd0);
    end
  end

  // issue one CPU instruction and hold it until the DUT stops stalling
  task automatic op(input int kind, input logic [31:0] adr, input logic [31:0] data, output int stalls);
    int k;
    k = kind;
    cpu_adr   = adr;
    cpu_wdata = data;
    cpu_read  = (k == K_LOAD) || (k == K_COMBO);
    cpu_write = (k == K_STORE) || (k == K_COMBO);
    cur_adr   = adr;
    cur_kind  = k;
    if (cpu_write) begin
      wq.push_back({adr, data});
      arch[adr[9:2]] = data;
    end
    if (k == K_LOAD) lq.push_back(arch[adr[9:2]]);
    stalls = 0;
    forever begin
      @(negedge clk);
      if (!cpu_stall) break;
      stalls++;
      if (stalls > 30) begin
        chk("stall_timeout", 32'(stalls), 32'd0);
        break;
      end
      if (k == K_COMBO) begin
        @(posedge clk); #1;
        cpu_read = 1'b0;
        k        = K_STORE;
        cur_kind = K_STORE;
      end
    end
    @(posedge clk); #1;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    cur_kind  = K_IDLE;
  endtask

  task automatic idle(input int n);
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    cur_kind  = K_IDLE;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic random_ops(input int n);
    int r, s;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 99);
      a = ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      if (r < 35)                            op(K_STORE, a, $urandom, s);
      else if (r < 70)                       op(K_LOAD, a, 32'd0, s);
      else if (r < 82 && wq.size() < DEPTH)  op(K_COMBO, a, $urandom, s);
      else                                   idle($urandom_range(1, 3));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  int s;
  initial begin
    for (int i = 0; i < 256; i++) arch[i] = init_val(i);
    cpu_adr = 32'h40; cpu_wdata = '0; cpu_read = 1'b1; cpu_write = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #11;
    chk("rst_count", 32'(buf_count), 32'd0);
    chk("rst_empty", 32'(buf_empty), 32'd1);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    cpu_read = 1'b0;
    #9 rst = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    idle(3);

    op(K_STORE, 32'h10, 32'h11, s);
    idle(3);

    op(K_COMBO, 32'h0, 32'h100, s);
    op(K_COMBO, 32'h4, 32'h104, s);
    op(K_COMBO, 32'h8, 32'h108, s);
    op(K_COMBO, 32'hC, 32'h10C, s);
    op(K_COMBO, 32'h10, 32'h110, s);
    chk("fill_stall_cycles", 32'(s), 32'd2);
    idle(6);

    op(K_STORE, 32'h20, 32'hA, s);
    op(K_STORE, 32'h20, 32'hB, s);
    op(K_LOAD, 32'h22, 32'd0, s);
    chk("same_word_load_stalls", 32'(s), HAZ ? 32'd1 : 32'd0);
    idle(3);

    op(K_STORE, 32'h30, 32'h33, s);
    op(K_LOAD, 32'h40, 32'd0, s);
    idle(3);

    random_ops(1500);
    idle(8);
    chk("drained_pending", 32'(wq.size()), 32'd0);
    chk("drained_loads", 32'(lq.size()), 32'd0);

    op(K_COMBO, 32'h4, 32'h55, s);
    op(K_COMBO, 32'h8, 32'h66, s);
    op(K_COMBO, 32'hC, 32'h77, s);
    mon_en = 1'b0;
    rst = 1'b0;
    #2;
    chk("midrst_count", 32'(buf_count), 32'd0);
    chk("midrst_mem_write", 32'(mem_write), 32'd0);
    chk("midrst_empty", 32'(buf_empty), 32'd1);
    wq.delete();
    lq.delete();
    for (int i = 0; i < 256; i++) arch[i] = init_val(i);
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    random_ops(300);
    idle(8);
    chk("final_pending", 32'(wq.size()), 32'd0);
    chk("final_empty", 32'(buf_empty), 32'd1);
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
